// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types and responder state encoding.
// Imported by the SRAM responder and its byte-enable array.
package dbus_sram_responder_pkg;

  typedef logic [63:0] u64;
  typedef logic [7:0]  strobe_t;

  typedef struct packed {
    logic       valid;
    u64         addr;
    logic [2:0] size;
    strobe_t    strobe;
    u64         data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } responder_state_t;

endpackage

// File: rtl/dbus_sram_responder_sram_be.sv
// Byte-enable 64-bit word array: sync write, comb read.
// Zero-filled on reset so a fresh run starts from known contents.
module sram_be
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  strobe_t               be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  u64                    wdata,
  output u64                    rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  u64 mem [DEPTH];

  // Clear on reset, otherwise merge enabled byte lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM slave: latches one request, answers after LATENCY.
// Out-of-range requests still handshake but never touch the array.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 12,
  parameter u64 BASE_ADDR  = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy
);

  localparam int OFFW = DEPTH_LOG2 + 3;

  responder_state_t state, state_nx;

  logic [3:0]            cnt;
  u64                    addr_q;
  u64                    data_q;
  strobe_t               strobe_q;
  u64                    off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  u64                    rdata;
  logic                  resp;
  logic                  we;
  logic                  accept;
  logic                  unused;

  assign off      = addr_q - BASE_ADDR;
  assign in_range = (off[63:OFFW] == '0);
  assign idx      = off[OFFW-1:3];
  assign resp     = (state == RESP) && !reset;
  assign we       = resp && (|strobe_q) && in_range;
  assign accept   = (state == IDLE) && dreq.valid;
  assign busy     = (state != IDLE);
  assign unused   = ^{dreq.size, off[2:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (dreq.valid)
              state_nx = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1)
              state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= '0;
    end else if (accept) begin
      cnt      <= 4'(LATENCY - 1);
      addr_q   <= dreq.addr;
      data_q   <= dreq.data;
      strobe_q <= dreq.strobe;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response drive: one-cycle pulse, data zero outside RESP.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = resp;
    dresp.data_ok = resp;
    if (resp && in_range) dresp.data = rdata;
  end

  sram_be #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .be   (strobe_q),
    .idx  (idx),
    .wdata(data_q),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for the dbus SRAM responder (LATENCY 2 and 3).
// Expected read data is queued at issue and popped on data_ok.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  logic       clk = 1'b0;
  logic       rst2;
  logic       rst3;
  dbus_req_t  req2;
  dbus_req_t  req3;
  dbus_resp_t rsp2;
  dbus_resp_t rsp3;
  logic       busy2;
  logic       busy3;

  int checks = 0;
  int errors = 0;
  u64 sb [$];

  always #5 clk = ~clk;

  dbus_sram_responder #(
    .LATENCY(2), .DEPTH_LOG2(12), .BASE_ADDR(64'h8000_0000)
  ) u2 (
    .clk(clk), .reset(rst2), .dreq(req2), .dresp(rsp2), .busy(busy2)
  );

  dbus_sram_responder #(
    .LATENCY(3), .DEPTH_LOG2(12), .BASE_ADDR(64'h8000_0000)
  ) u3 (
    .clk(clk), .reset(rst3), .dreq(req3), .dresp(rsp3), .busy(busy3)
  );

  task automatic chk(input string tag, input u64 obs, input u64 exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int which, input dbus_req_t r);
    if (which == 3) req3 = r;
    else            req2 = r;
  endtask

  // Caller is at a negedge; request is sampled at the next posedge.
  task automatic txn(input int which, input string tag, input u64 addr,
                     input strobe_t st, input u64 data, input bit change,
                     input u64 exp);
    dbus_req_t  r;
    dbus_resp_t o;
    logic       b;
    int         lat;
    lat = (which == 3) ? 3 : 2;
    r = '0;
    r.valid = 1'b1;
    r.addr = addr;
    r.size = 3'd3;
    r.strobe = st;
    r.data = data;
    sb.push_back(exp);
    set_req(which, r);
    @(posedge clk);
    #1;
    r.valid = 1'b0;
    if (change) begin
      r.addr = 64'h8000_0100;
      r.strobe = 8'h00;
    end
    set_req(which, r);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      o = (which == 3) ? rsp3 : rsp2;
      b = (which == 3) ? busy3 : busy2;
      chk({tag, "_addr_ok"}, 64'(o.addr_ok), 64'(k == lat));
      chk({tag, "_data_ok"}, 64'(o.data_ok), 64'(k == lat));
      chk({tag, "_busy"}, 64'(b), 64'(k <= lat));
      if (o.data_ok) begin
        if (sb.size() > 0) chk({tag, "_data"}, o.data, sb.pop_front());
        else chk({tag, "_extra_resp"}, 64'd1, 64'd0);
      end else begin
        chk({tag, "_idle_data"}, o.data, 64'd0);
      end
    end
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    dbus_req_t r;
    rst2 = 1'b1;
    rst3 = 1'b1;
    req2 = '0;
    req3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    chk("rst_addr_ok", 64'(rsp2.addr_ok), 64'd0);
    chk("rst_data_ok", 64'(rsp2.data_ok), 64'd0);
    chk("rst_data", rsp2.data, 64'd0);
    chk("rst_busy", 64'(busy2), 64'd0);
    chk("rst_busy3", 64'(busy3), 64'd0);

    txn(2, "rd0", 64'h8000_0010, 8'h00, 64'd0, 1'b0, 64'd0);
    txn(2, "wr_full", 64'h8000_0008, 8'hFF,
        64'h1122_3344_5566_7788, 1'b0, 64'd0);
    txn(2, "rd_full", 64'h8000_000C, 8'h00, 64'd0, 1'b0,
        64'h1122_3344_5566_7788);
    txn(2, "wr_part", 64'h8000_0008, 8'h0F,
        64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'h1122_3344_5566_7788);
    txn(2, "rd_part", 64'h8000_0008, 8'h00, 64'd0, 1'b0,
        64'h1122_3344_AAAA_AAAA);
    txn(2, "wr_100", 64'h8000_0100, 8'hFF,
        64'hDEAD_BEEF_0000_0001, 1'b0, 64'd0);
    txn(2, "rd_chg", 64'h8000_0008, 8'h00, 64'd0, 1'b1,
        64'h1122_3344_AAAA_AAAA);
    txn(2, "rd_100", 64'h8000_0100, 8'h00, 64'd0, 1'b0,
        64'hDEAD_BEEF_0000_0001);
    txn(2, "wr_top", 64'h8000_7FF8, 8'hFF,
        64'h5555_5555_5555_5555, 1'b0, 64'd0);
    txn(2, "rd_under", 64'h7FFF_FFF8, 8'h00, 64'd0, 1'b0, 64'd0);
    txn(2, "wr_over", 64'h8000_8000, 8'hFF,
        64'hCAFE_CAFE_CAFE_CAFE, 1'b0, 64'd0);
    txn(2, "rd_w0", 64'h8000_0000, 8'h00, 64'd0, 1'b0, 64'd0);
    txn(2, "rd_top", 64'h8000_7FF8, 8'h00, 64'd0, 1'b0,
        64'h5555_5555_5555_5555);

    txn(3, "l3_wr", 64'h8000_0020, 8'hFF,
        64'h7777_0000_7777_0000, 1'b0, 64'd0);
    txn(3, "l3_rd", 64'h8000_0020, 8'h00, 64'd0, 1'b0,
        64'h7777_0000_7777_0000);

    r = '0;
    r.valid = 1'b1;
    r.addr = 64'h8000_0028;
    r.strobe = 8'hFF;
    r.data = 64'h9999_9999_9999_9999;
    req3 = r;
    @(posedge clk);
    #1;
    req3.valid = 1'b0;
    rst3 = 1'b1;
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("l3_rst_data_ok", 64'(rsp3.data_ok), 64'd0);
      chk("l3_rst_busy", 64'(busy3), 64'd0);
    end
    txn(3, "l3_rd_after", 64'h8000_0028, 8'h00, 64'd0, 1'b0, 64'd0);

    r = '0;
    r.valid = 1'b1;
    r.addr = 64'h8000_0100;
    req2 = r;
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    req2.valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstwin_data_ok", 64'(rsp2.data_ok), 64'd0);
      chk("rstwin_busy", 64'(busy2), 64'd0);
    end
    txn(2, "rd_cleared", 64'h8000_0100, 8'h00, 64'd0, 1'b0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
